puzzle_move_ctrl: RTL

PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

---
 rtl/puzzle_move_ctrl_if.sv | 27 ++
 rtl/puzzle_move_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_move_ctrl_if.sv
// Button, frame-timing and board-state signals between the sliding-puzzle controller and its environment.
// slave is the controller side; master drives buttons/requests and observes the board.
interface puzzle_move_ctrl_if;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         btn_center;
    logic         shuffle_req;
    logic         frame_tick;
    logic [124:0] board;
    logic [4:0]   cursor_pos;
    logic [4:0]   blank_pos;
    logic [15:0]  move_count;
    logic         solved;
    logic         busy;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_center, shuffle_req, frame_tick,
        input  board, cursor_pos, blank_pos, move_count, solved, busy
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_center, shuffle_req, frame_tick,
        output board, cursor_pos, blank_pos, move_count, solved, busy
    );
endinterface

// File: rtl/puzzle_move_ctrl.sv
// 5x5 sliding-puzzle controller: debounced buttons move a cursor or slide a tile into the blank, LFSR shuffle, solved scan.
// Latency: button event waits for frame_tick, 1-cycle APPLY, 25-cycle CHECK after a swap; shuffle takes SHUFFLE_MOVES+25 cycles.
// Backpressure: none; button events and shuffle requests arriving while busy are dropped, never queued.
module puzzle_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SHUFFLE_MOVES   = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    puzzle_move_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SHUFFLE_MOVES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        APPLY,
        CHECK,
        SHUFFLE
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_CENTER
    } act_t;

    // Bit order: 4 center, 3 up, 2 down, 1 left, 0 right
    logic [4:0]    btn_raw;
    logic [1:0]    sync [5];
    logic [CW-1:0] cnt  [5];
    logic [4:0]    evt;

    assign btn_raw = {bus.btn_center, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

    // Counter saturates at DEBOUNCE_CYCLES so a held button fires once; a sampled low re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 5; b++) begin
                sync[b] <= 2'b00;
                cnt[b]  <= '0;
            end
            evt <= '0;
        end else begin
            for (int b = 0; b < 5; b++) begin
                sync[b] <= {sync[b][0], btn_raw[b]};
                if (!sync[b][1]) begin
                    cnt[b] <= '0;
                    evt[b] <= 1'b0;
                end else if (cnt[b] != CW'(DEBOUNCE_CYCLES)) begin
                    cnt[b] <= cnt[b] + 1'b1;
                    evt[b] <= (cnt[b] == CW'(DEBOUNCE_CYCLES - 1));
                end else begin
                    evt[b] <= 1'b0;
                end
            end
        end
    end

    act_t evt_act;

    always_comb begin
        evt_act = ACT_NONE;
        if (evt[4])      evt_act = ACT_CENTER;
        else if (evt[3]) evt_act = ACT_UP;
        else if (evt[2]) evt_act = ACT_DOWN;
        else if (evt[1]) evt_act = ACT_LEFT;
        else if (evt[0]) evt_act = ACT_RIGHT;
    end

    state_t        state;
    act_t          act;
    logic [4:0]    cells [25];
    logic [4:0]    cursor_q;
    logic [4:0]    blank_q;
    logic [15:0]   move_q;
    logic          solved_q;
    logic          busy_q;
    logic [SW-1:0] step;
    logic [4:0]    chk_idx;
    logic          chk_ok;
    logic [15:0]   lfsr;

    logic [2:0] cur_row, cur_col, blk_row, blk_col;
    logic       adjacent;

    assign cur_row = 3'(cursor_q / 5'd5);
    assign cur_col = 3'(cursor_q % 5'd5);
    assign blk_row = 3'(blank_q / 5'd5);
    assign blk_col = 3'(blank_q % 5'd5);

    assign adjacent = ((cur_row == blk_row) && ((cur_col == blk_col + 3'd1) || (blk_col == cur_col + 3'd1))) ||
                      ((cur_col == blk_col) && ((cur_row == blk_row + 3'd1) || (blk_row == cur_row + 3'd1)));

    // Shuffle step: LFSR[1:0] picks the neighbour the blank slides to; edge-illegal picks are wasted steps.
    logic       shf_legal;
    logic [4:0] shf_tgt;

    always_comb begin
        shf_legal = 1'b0;
        shf_tgt   = blank_q;
        case (lfsr[1:0])
            2'd0: if (blank_q >= 5'd5)  begin shf_legal = 1'b1; shf_tgt = blank_q - 5'd5; end
            2'd1: if (blank_q < 5'd20)  begin shf_legal = 1'b1; shf_tgt = blank_q + 5'd5; end
            2'd2: if (blk_col != 3'd0)  begin shf_legal = 1'b1; shf_tgt = blank_q - 5'd1; end
            default: if (blk_col != 3'd4) begin shf_legal = 1'b1; shf_tgt = blank_q + 5'd1; end
        endcase
    end

    logic [4:0] chk_exp;
    logic       chk_ok_n;

    assign chk_exp  = (chk_idx == 5'd24) ? 5'd0 : chk_idx + 5'd1;
    assign chk_ok_n = chk_ok && (cells[chk_idx] == chk_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            act      <= ACT_NONE;
            for (int i = 0; i < 25; i++) begin
                cells[i] <= (i < 24) ? 5'(i + 1) : 5'd0;
            end
            cursor_q <= 5'd0;
            blank_q  <= 5'd24;
            move_q   <= 16'd0;
            solved_q <= 1'b1;
            busy_q   <= 1'b0;
            step     <= '0;
            chk_idx  <= 5'd0;
            chk_ok   <= 1'b1;
            lfsr     <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            case (state)
                IDLE: begin
                    if (bus.shuffle_req) begin
                        state    <= SHUFFLE;
                        busy_q   <= 1'b1;
                        solved_q <= 1'b0;
                        step     <= '0;
                    end else if (evt_act != ACT_NONE) begin
                        act    <= evt_act;
                        state  <= WAIT_FRAME;
                        busy_q <= 1'b1;
                    end
                end

                // Board/cursor only change after vertical blanking begins, so a frame never shows a half move.
                WAIT_FRAME: begin
                    if (bus.frame_tick) begin
                        state <= APPLY;
                    end
                end

                APPLY: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    case (act)
                        ACT_UP:    if (cursor_q >= 5'd5)  cursor_q <= cursor_q - 5'd5;
                        ACT_DOWN:  if (cursor_q < 5'd20)  cursor_q <= cursor_q + 5'd5;
                        ACT_LEFT:  if (cur_col != 3'd0)   cursor_q <= cursor_q - 5'd1;
                        ACT_RIGHT: if (cur_col != 3'd4)   cursor_q <= cursor_q + 5'd1;
                        ACT_CENTER: begin
                            if (adjacent) begin
                                cells[cursor_q] <= 5'd0;
                                cells[blank_q]  <= cells[cursor_q];
                                blank_q         <= cursor_q;
                                if (move_q != 16'hFFFF) begin
                                    move_q <= move_q + 16'd1;
                                end
                                solved_q <= 1'b0;
                                state    <= CHECK;
                                busy_q   <= 1'b1;
                                chk_idx  <= 5'd0;
                                chk_ok   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end

                CHECK: begin
                    if (chk_idx == 5'd24) begin
                        solved_q <= chk_ok_n;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        chk_idx <= chk_idx + 5'd1;
                        chk_ok  <= chk_ok_n;
                    end
                end

                SHUFFLE: begin
                    if (shf_legal) begin
                        cells[blank_q] <= cells[shf_tgt];
                        cells[shf_tgt] <= 5'd0;
                        blank_q        <= shf_tgt;
                    end
                    if (step == SW'(SHUFFLE_MOVES - 1)) begin
                        move_q   <= 16'd0;
                        cursor_q <= shf_legal ? shf_tgt : blank_q;
                        state    <= CHECK;
                        chk_idx  <= 5'd0;
                        chk_ok   <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    logic [124:0] board_flat;

    always_comb begin
        board_flat = '0;
        for (int i = 0; i < 25; i++) begin
            board_flat[5*i +: 5] = cells[i];
        end
    end

    assign bus.board      = board_flat;
    assign bus.cursor_pos = cursor_q;
    assign bus.blank_pos  = blank_q;
    assign bus.move_count = move_q;
    assign bus.solved     = solved_q;
    assign bus.busy       = busy_q;

endmodule
